// File: rtl/spatz_xmem_pkg.sv
// Shared types for the Spatz X-interface memory responder: id type,
// outstanding-access metadata and the burst tracking state.
package spatz_xmem_pkg;

    localparam int unsigned IdWidth = 3;

    typedef logic [IdWidth-1:0] id_t;

    typedef struct packed {
        id_t  id;
        logic is_load;
    } meta_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } burst_state_e;

endpackage

// File: rtl/spatz_xmem_responder_if.sv
// X-interface memory request/result bundle between the VLSU (master) and
// the memory-side responder (slave).
interface spatz_xmem_responder_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 3
);
    logic                   valid;
    logic                   ready;
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] strb;
    logic [DataWidth-1:0]   wdata;
    logic                   last;
    logic                   result_valid;
    logic [IdWidth-1:0]     result_id;
    logic [DataWidth-1:0]   result_rdata;

    modport master (
        output valid, id, addr, we, strb, wdata, last,
        input  ready, result_valid, result_id, result_rdata
    );

    modport slave (
        input  valid, id, addr, we, strb, wdata, last,
        output ready, result_valid, result_id, result_rdata
    );
endinterface

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 parameter set; a full FIFO
// never accepts a push, even if a pop happens in the same cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam int unsigned CntW = ADDR_DEPTH + 1;

    dtype                  mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  bypass, do_push, do_pop;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + ADDR_DEPTH'(1);
    endfunction

    always_comb begin
        full_o   = (cnt_q == CntW'(DEPTH));
        bypass   = FALL_THROUGH && (cnt_q == '0) && push_i;
        empty_o  = (cnt_q == '0) && !bypass;
        usage_o  = cnt_q[ADDR_DEPTH-1:0];
        data_o   = bypass ? data_i : mem_q[rd_ptr_q];
        do_push  = push_i && !full_o && !(bypass && pop_i);
        do_pop   = pop_i && !empty_o && !bypass;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/spatz_xmem_responder.sv
// Memory-side responder for one VLSU port: forwards x_mem requests to an
// in-order grant/rvalid SRAM port and returns id-tagged load results.
// Optional macro SPATZ_XMEM_RESP_REG_EN registers the result and done outputs.
module spatz_xmem_responder #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned IdWidth       = 3,   // must match spatz_xmem_pkg::IdWidth
    parameter int unsigned NrOutstanding = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    spatz_xmem_responder_if.slave  x_mem,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic                   burst_busy_o,
    output logic                   burst_done_o
);
    import spatz_xmem_pkg::*;

    localparam int unsigned PtrW = $clog2(NrOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    logic                 full, empty, accept, pop;
    logic [PtrW-1:0]      usage;
    logic [CntW-1:0]      count, count_d;
    meta_t                meta_in, meta_head;
    burst_state_e         state_q, state_d;
    logic                 done_raw;
    logic                 res_valid;
    logic [IdWidth-1:0]   res_id;
    logic [DataWidth-1:0] res_rdata;

    assign mem_req_o   = x_mem.valid & ~full;
    assign mem_addr_o  = x_mem.addr;
    assign mem_we_o    = x_mem.we;
    assign mem_wdata_o = x_mem.wdata;
    assign mem_be_o    = x_mem.we ? x_mem.strb : '1;
    assign x_mem.ready = mem_gnt_i & ~full;
    assign accept      = x_mem.valid & x_mem.ready;
    // Responses with nothing outstanding are dropped here.
    assign pop         = mem_rvalid_i & ~empty;

    assign meta_in.id      = id_t'(x_mem.id);
    assign meta_in.is_load = ~x_mem.we;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (NrOutstanding),
        .dtype        (meta_t)
    ) i_meta_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (usage),
        .data_i  (meta_in),
        .push_i  (accept),
        .data_o  (meta_head),
        .pop_i   (pop)
    );

    // usage wraps to zero when full, so rebuild the true occupancy.
    assign count   = full ? CntW'(NrOutstanding) : {1'b0, usage};
    assign count_d = count + CntW'(accept) - CntW'(pop);

    assign res_valid = pop & meta_head.is_load;
    assign res_id    = res_valid ? IdWidth'(meta_head.id) : '0;
    assign res_rdata = res_valid ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept) state_d = x_mem.last ? DRAIN : ACTIVE;
            ACTIVE: if (accept && x_mem.last) state_d = DRAIN;
            DRAIN: begin
                if (count_d == '0) state_d = accept ? (x_mem.last ? DRAIN : ACTIVE) : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        burst_busy_o = (state_q != IDLE);
        done_raw     = (state_q == DRAIN) && (count_d == '0);
    end

`ifdef SPATZ_XMEM_RESP_REG_EN
    logic                 res_valid_q, done_q;
    logic [IdWidth-1:0]   res_id_q;
    logic [DataWidth-1:0] res_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            res_valid_q <= res_valid;
            res_id_q    <= res_id;
            res_rdata_q <= res_rdata;
            done_q      <= done_raw;
        end
    end

    assign x_mem.result_valid = res_valid_q;
    assign x_mem.result_id    = res_id_q;
    assign x_mem.result_rdata = res_rdata_q;
    assign burst_done_o       = done_q;
`else
    assign x_mem.result_valid = res_valid;
    assign x_mem.result_id    = res_id;
    assign x_mem.result_rdata = res_rdata;
    assign burst_done_o       = done_raw;
`endif

`ifndef SYNTHESIS
    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> !empty)
        else $warning("spatz_xmem_responder: mem_rvalid_i with no outstanding access, response dropped");
`endif
endmodule

// File: tb/tb_spatz_xmem_responder.sv
// Randomized bench for spatz_xmem_responder against a queue-based model of
// outstanding accesses, an in-order SRAM and burst open/close tracking.
module tb_spatz_xmem_responder;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int NO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_req, mem_gnt, mem_we, mem_rvalid, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    spatz_xmem_responder_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) xif ();

    spatz_xmem_responder #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .NrOutstanding(NO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .x_mem(xif),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .burst_busy_o(busy), .burst_done_o(done)
    );

    typedef struct {
        logic [IW-1:0] id; logic we; logic [DW/8-1:0] strb; logic [DW-1:0] wdata;
        logic [AW-1:0] addr; logic last; logic [DW-1:0] rdata;
    } req_t;
    typedef struct { logic [IW-1:0] id; logic is_load; logic [DW-1:0] rdata; } out_t;
    typedef struct { int due; logic [DW-1:0] rdata; } rsp_t;

    req_t req_q[$];   // requester stream not yet accepted
    out_t ref_q[$];   // model: accesses granted but not yet answered
    rsp_t sram_q[$];  // SRAM responses still to be delivered

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 2;
    bit rand_lat = 0;
    bit hold_rsp = 0;
    int gnt_pct = 100;
    bit last_seen = 0, active_seen = 0;
    int n_dut_res = 0, n_dut_done = 0;
    logic obs_ready, obs_req, obs_busy;
    logic prev_rv = 1'b0, prev_done = 1'b0;
    logic [IW-1:0] prev_id = '0;
    logic [DW-1:0] prev_rd = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic add_req(input logic [IW-1:0] id, input logic we, input logic [DW/8-1:0] strb,
                           input logic [DW-1:0] wdata, input logic last, input logic [DW-1:0] rdata);
        req_t r;
        r.id = id; r.we = we; r.strb = strb; r.wdata = wdata; r.last = last; r.rdata = rdata;
        r.addr = $urandom;
        r.addr[1:0] = 2'b00;
        req_q.push_back(r);
    endtask

    task automatic step();
        logic acc, pop, exp_rv, exp_done, exp_busy, exp_ready, exp_req, full_m;
        logic [IW-1:0] exp_id;
        logic [DW-1:0] exp_rd;
        int after;
        out_t o;
        rsp_t s;
        @(negedge clk);
        if (req_q.size() > 0) begin
            xif.valid = 1'b1; xif.id = req_q[0].id; xif.addr = req_q[0].addr; xif.we = req_q[0].we;
            xif.strb = req_q[0].strb; xif.wdata = req_q[0].wdata; xif.last = req_q[0].last;
        end else begin
            xif.valid = 1'b0; xif.id = '0; xif.addr = '0; xif.we = 1'b0;
            xif.strb = '0; xif.wdata = '0; xif.last = 1'b0;
        end
        mem_gnt = ($urandom_range(99) < gnt_pct);
        if (!hold_rsp && sram_q.size() > 0 && sram_q[0].due <= cyc) begin
            mem_rvalid = 1'b1; mem_rdata = sram_q[0].rdata;
        end else begin
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
        #1;
        full_m    = (ref_q.size() == NO);
        exp_ready = mem_gnt && !full_m;
        exp_req   = xif.valid && !full_m;
        acc       = xif.valid && exp_ready;
        pop       = mem_rvalid && (ref_q.size() > 0);
        exp_rv = 1'b0; exp_id = '0; exp_rd = '0;
        if (pop) begin
            exp_rv = ref_q[0].is_load; exp_id = ref_q[0].id; exp_rd = ref_q[0].rdata;
        end
        after    = ref_q.size() + int'(acc) - int'(pop);
        exp_done = last_seen && (after == 0);
        exp_busy = last_seen || active_seen;

        check_eq("ready", xif.ready, exp_ready);
        check_eq("mem_req", mem_req, exp_req);
        if (xif.valid) begin
            check_eq("mem_addr", mem_addr, xif.addr);
            check_eq("mem_we", mem_we, xif.we);
            check_eq("mem_be", mem_be, xif.we ? xif.strb : 4'hF);
            check_eq("mem_wdata", mem_wdata, xif.wdata);
        end
        check_eq("busy", busy, exp_busy);
`ifdef SPATZ_XMEM_RESP_REG_EN
        check_eq("res_valid", xif.result_valid, prev_rv);
        if (prev_rv) begin
            check_eq("res_id", xif.result_id, prev_id);
            check_eq("res_rdata", xif.result_rdata, prev_rd);
        end
        check_eq("done", done, prev_done);
        prev_rv = exp_rv; prev_id = exp_id; prev_rd = exp_rd; prev_done = exp_done;
`else
        check_eq("res_valid", xif.result_valid, exp_rv);
        if (exp_rv) begin
            check_eq("res_id", xif.result_id, exp_id);
            check_eq("res_rdata", xif.result_rdata, exp_rd);
        end
        check_eq("done", done, exp_done);
`endif
        obs_ready = xif.ready; obs_req = mem_req; obs_busy = busy;
        if (xif.result_valid === 1'b1) n_dut_res++;
        if (done === 1'b1) n_dut_done++;

        @(posedge clk);
        cyc++;
        if (mem_rvalid) sram_q.delete(0);
        if (pop) ref_q.delete(0);
        if (acc) begin
            o.id = xif.id; o.is_load = !xif.we; o.rdata = req_q[0].rdata;
            ref_q.push_back(o);
            s.due = cyc - 1 + (rand_lat ? int'($urandom_range(1, 4)) : lat);
            s.rdata = req_q[0].rdata;
            sram_q.push_back(s);
            req_q.delete(0);
        end
        if (exp_done) begin last_seen = 0; active_seen = 0; end
        if (acc) begin
            if (xif.last) last_seen = 1;
            else          active_seen = 1;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((req_q.size() > 0 || sram_q.size() > 0 || ref_q.size() > 0 ||
                last_seen || active_seen) && n < budget) begin
            step();
            n++;
        end
        check_eq("idle_within_budget", n < budget, 1'b1);
        repeat (2) step();
    endtask

    initial begin
        int r0, d0;
        xif.valid = 1'b0; xif.id = '0; xif.addr = '0; xif.we = 1'b0;
        xif.strb = '0; xif.wdata = '0; xif.last = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        check_eq("rst_res_valid", xif.result_valid, 1'b0);
        check_eq("rst_res_id", xif.result_id, '0);
        check_eq("rst_res_rdata", xif.result_rdata, '0);
        check_eq("rst_ready", xif.ready, 1'b0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, '0);
        check_eq("rst_mem_wdata", mem_wdata, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Eight back-to-back loads, one burst.
        r0 = n_dut_res; d0 = n_dut_done;
        for (int i = 0; i < 8; i++)
            add_req(IW'(i), 1'b0, 4'h0, '0, i == 7, 32'hA0 + i);
        run_until_idle(60);
        check_eq("s1_results", n_dut_res - r0, 8);
        check_eq("s1_done_pulses", n_dut_done - d0, 1);

        // Fill the meta FIFO with responses held back.
        hold_rsp = 1;
        for (int i = 0; i < 9; i++)
            add_req(IW'(i), 1'b0, 4'h0, '0, i == 8, $urandom);
        repeat (14) step();
        check_eq("s2_ready_when_full", obs_ready, 1'b0);
        check_eq("s2_req_when_full", obs_req, 1'b0);
        check_eq("s2_ninth_pending", req_q.size(), 1);
        hold_rsp = 0;
        step();
        check_eq("s2_ready_on_pop_cycle", obs_ready, 1'b0);
        hold_rsp = 1;
        step();
        check_eq("s2_ready_after_pop", obs_ready, 1'b1);
        hold_rsp = 0;
        run_until_idle(60);

        // Single store: no result.
        r0 = n_dut_res;
        add_req(3'd3, 1'b1, 4'b0101, 32'hDEADBEEF, 1'b1, $urandom);
        run_until_idle(30);
        check_eq("s3_store_results", n_dut_res - r0, 0);

        // L,S,L(last) with responses overlapping new accepts.
        lat = 1; r0 = n_dut_res; d0 = n_dut_done;
        add_req(3'd1, 1'b0, 4'h0, '0, 1'b0, 32'h11110001);
        add_req(3'd2, 1'b1, 4'hF, 32'h55AA55AA, 1'b0, $urandom);
        add_req(3'd4, 1'b0, 4'h0, '0, 1'b1, 32'h44440004);
        run_until_idle(30);
        check_eq("s4_results", n_dut_res - r0, 2);
        check_eq("s4_done_pulses", n_dut_done - d0, 1);

        // Random traffic.
        lat = 2; rand_lat = 1; gnt_pct = 70;
        for (int i = 0; i < 150; i++)
            add_req(IW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom),
                    $urandom, (i == 149) || ($urandom_range(0, 7) == 0), $urandom);
        run_until_idle(3000);
        rand_lat = 0; gnt_pct = 100;

        // Asynchronous reset with four accesses outstanding, then stray responses.
        hold_rsp = 1;
        for (int i = 0; i < 4; i++)
            add_req(IW'(i), 1'b0, 4'h0, '0, 1'b0, $urandom);
        repeat (6) step();
        check_eq("s5_busy_before_reset", obs_busy, 1'b1);
        @(negedge clk);
        xif.valid = 1'b0; mem_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("s5_rst_busy", busy, 1'b0);
        check_eq("s5_rst_res_valid", xif.result_valid, 1'b0);
        check_eq("s5_rst_done", done, 1'b0);
        ref_q.delete(); req_q.delete();
        last_seen = 0; active_seen = 0; prev_rv = 1'b0; prev_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hold_rsp = 0;
        r0 = n_dut_res;
        check_eq("s5_stray_pending", sram_q.size(), 4);
        run_until_idle(50);
        check_eq("s5_stray_results", n_dut_res - r0, 0);
        check_eq("s5_idle_after_stray", obs_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spatz_xmem_responder.md
Name: spatz_xmem_responder

Overview:
- Memory-side responder for the Spatz X-interface memory protocol. Accepts the VLSU's `x_mem` requests (id, addr, we, strb, wdata, last) and issues them to a single-port, in-order, grant/rvalid SRAM/TCDM port.
- Returns load results to the requester tagged with the original request id.
- Tracks outstanding accesses and burst (`last`) boundaries. One instance sits behind each VLSU memory port.

Parameters:
- AddrWidth, 32, request/SRAM address width.
- DataWidth, 32, data width; equals ELEN.
- IdWidth, 3, request/result id width; equals idx_width(NrOutstanding) on the requester side.
- NrOutstanding, 8, maximum granted-but-not-returned SRAM accesses; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- x_mem_valid_i  in  1  request valid
- x_mem_ready_o  out  1  request accepted this cycle
- x_mem_id_i  in  IdWidth  request id
- x_mem_addr_i  in  AddrWidth  word-aligned byte address
- x_mem_we_i  in  1  1=store, 0=load
- x_mem_strb_i  in  DataWidth/8  store byte strobes
- x_mem_wdata_i  in  DataWidth  store data
- x_mem_last_i  in  1  final beat of the current instruction
- x_mem_result_valid_o  out  1  load result valid (no back-pressure)
- x_mem_result_id_o  out  IdWidth  id of returned load
- x_mem_result_rdata_o  out  DataWidth  load data
- mem_req_o  out  1  SRAM request
- mem_gnt_i  in  1  SRAM grant
- mem_addr_o  out  AddrWidth  SRAM address
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  DataWidth/8  SRAM byte enables
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_rvalid_i  in  1  SRAM response; one per grant, in order, loads and stores
- mem_rdata_i  in  DataWidth  SRAM read data
- burst_busy_o  out  1  burst in progress or draining
- burst_done_o  out  1  one-cycle pulse when a burst fully completes

Behaviour:
- Reset values: all outputs 0; meta FIFO empty; outstanding count 0; FSM IDLE.
- Request side:
  - mem_req_o = x_mem_valid_i & ~full.
  - mem_addr_o / mem_we_o / mem_wdata_o pass through combinationally.
  - mem_be_o = x_mem_strb_i for stores, all-ones for loads.
  - x_mem_ready_o = mem_gnt_i & ~full; the grant-to-ready path is combinational.
  - accept = x_mem_valid_i & x_mem_ready_o.
- Meta FIFO:
  - Depth NrOutstanding; entry = {id, is_load}.
  - Pushed on accept, popped on mem_rvalid_i.
  - full = count == NrOutstanding. No same-cycle pop bypass while full: ready stays 0 that cycle.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo NrOutstanding.
- Response side:
  - On mem_rvalid_i with head.is_load: x_mem_result_valid_o=1, id=head.id, rdata=mem_rdata_i unmodified. The requester performs byte rotation.
  - Store responses are consumed silently.
  - Latency: 0 cycles from mem_rvalid_i to result.
- mem_rvalid_i with an empty FIFO is a protocol violation: flag it with an assertion and ignore the response. This also covers responses arriving after a mid-operation reset.
- Burst FSM:
  - IDLE: accept & ~last -> ACTIVE; accept & last -> DRAIN.
  - ACTIVE: accept & last -> DRAIN.
  - DRAIN: count_next == 0 -> IDLE with burst_done_o=1 for that cycle. A new accept while in DRAIN is legal; it extends the drain. A new-burst accept in the same cycle as the done transition goes to ACTIVE or DRAIN per its last bit, and done still pulses.
  - burst_busy_o = state != IDLE.
- Asynchronous reset mid-operation: FIFO, count and FSM clear immediately; no result is emitted for lost entries.

Optional Feature:
- Macro: SPATZ_XMEM_RESP_REG_EN.
- Defined: the result valid/id/rdata pass through one output register stage, giving 1-cycle response latency. Registered valid resets to 0. burst_done_o is delayed by one cycle so it is never seen before the last result.
- Undefined: combinational 0-cycle results as described above.

Decomposition:
- Shared package spatz_xmem_pkg holds:
  - the meta entry typedef {id_t id; logic is_load}
  - the burst FSM state enum {IDLE, ACTIVE, DRAIN}
  - id_t, derived from IdWidth
- Sub-module: the meta FIFO is a fifo_v3 instance from common_cells (DEPTH=NrOutstanding, FALL_THROUGH=0); no custom sub-module.

Test Plan:
- 8 back-to-back loads, ids 0..7, gnt=1, rvalid 2 cycles after each grant with rdata=0xA0+id -> results ids 0..7 in order with rdata 0xA0..0xA7; one burst_done_o pulse after the 8th result.
- Hold rvalid=0 and issue 9 loads -> ready drops after the 8th accept and mem_req_o=0; on one rvalid, the 9th is accepted no earlier than the next cycle.
- Store id=3, strb=0b0101, wdata=0xDEADBEEF -> mem_be_o=0101, mem_we_o=1; rvalid produces no result_valid.
- Mixed burst L,S,L(last) with rvalid at the cycle of a new accept -> count unchanged, results only for the two loads, FSM goes DRAIN->IDLE with done once.
- Assert rst_ni low with 4 outstanding, then deliver 4 stray rvalids -> no result_valid, assertion fires, FSM stays IDLE.
- With SPATZ_XMEM_RESP_REG_EN defined, repeat scenario 1 -> each result appears exactly one cycle later; done pulse is also delayed by one cycle.
